// File: rtl/rotary_pkg.sv
// rotary_pkg
//   Shared definitions for the rotary encoder emulator: command op encodings,
//   idle line levels, the FSM state enumeration and a helper that maps a
//   state onto the {leading, trailing} quadrature line levels.
package rotary_pkg;

    localparam logic [1:0] ROT_OP_CW   = 2'd0;  // B leads
    localparam logic [1:0] ROT_OP_CCW  = 2'd1;  // A leads
    localparam logic [1:0] ROT_OP_BTN  = 2'd2;  // single-cycle push on Rot_C
    localparam logic [1:0] ROT_OP_RSVD = 2'd3;  // accepted, no activity

    localparam logic ROT_AB_IDLE = 1'b1;
    localparam logic ROT_C_IDLE  = 1'b0;

    localparam int ROT_TMR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_GAP  = 3'd4,
        ST_BTN  = 3'd5
    } rot_state_e;

    // Returns {leading, trailing} line levels for a state. The leading line
    // falls first and rises first; A/B assignment depends on direction.
    function automatic logic [1:0] phase_levels(input rot_state_e st);
        logic [1:0] lv;
        case (st)
            ST_PH1:  lv = {1'b0, ROT_AB_IDLE};
            ST_PH2:  lv = 2'b00;
            ST_PH3:  lv = {ROT_AB_IDLE, 1'b0};
            default: lv = {ROT_AB_IDLE, ROT_AB_IDLE};
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/rotary_phase_timer.sv
// rotary_phase_timer
//   8-bit loadable down-counter shared by every timed state of the emulator.
//   Loading value N-1 on the edge a state is entered makes tc_o rise for the
//   last of N cycles, so the FSM leaves the state on the N-th edge.
//
//   Ports:
//     Fg_clk      in   system clock
//     Resetn      in   asynchronous active-low reset
//     load_i      in   load load_val_i on this edge (has priority)
//     load_val_i  in   cycles-minus-one of the state being entered
//     tc_o        out  terminal count: counter is at zero
module rotary_phase_timer
    import rotary_pkg::*;
(
    input  logic                 Fg_clk,
    input  logic                 Resetn,
    input  logic                 load_i,
    input  logic [ROT_TMR_W-1:0] load_val_i,
    output logic                 tc_o
);

    logic [ROT_TMR_W-1:0] count_q;
    logic [ROT_TMR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - {{(ROT_TMR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/rotary_emulator.sv
// rotary_emulator
//   Produces the Rot_A/Rot_B quadrature waveforms and the Rot_C button pulse
//   of a mechanical rotary encoder, for a commanded number of detents in
//   either direction or a single button press. All line outputs and done are
//   registered so the downstream decoder sees glitch-free levels.
//
//   Ports:
//     Fg_clk     in   system clock
//     Resetn     in   asynchronous active-low reset
//     cmd_valid  in   command offered
//     cmd_ready  out  idle, command will be accepted
//     cmd_op     in   0 CW, 1 CCW, 2 button, 3 reserved
//     cmd_count  in   detent count for ops 0/1
//     cmd_abort  in   level, stop after the current detent completes
//     Rot_A/B    out  quadrature lines, idle high
//     Rot_C      out  button line, idle low, one-cycle pulse
//     busy       out  command in progress
//     done       out  one-cycle pulse when a command retires
//     remaining  out  detents still to emit including the one in progress
module rotary_emulator
    import rotary_pkg::*;
#(
    parameter int PHASE_CYC = 8,
    parameter int GAP_CYC   = 16,
    parameter int CNT_W     = 11
) (
    input  logic             Fg_clk,
    input  logic             Resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_abort,
    output logic             Rot_A,
    output logic             Rot_B,
    output logic             Rot_C,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    if (PHASE_CYC < 4 || PHASE_CYC > 255) begin : g_bad_phase
        $error("rotary_emulator: PHASE_CYC out of range 4..255");
    end
    if (GAP_CYC < 4 || GAP_CYC > 255) begin : g_bad_gap
        $error("rotary_emulator: GAP_CYC out of range 4..255");
    end

    localparam logic [ROT_TMR_W-1:0] PH_LOAD  = ROT_TMR_W'(PHASE_CYC - 1);
    localparam logic [ROT_TMR_W-1:0] GAP_LOAD = ROT_TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0]     REM_ONE  = CNT_W'(1);

    rot_state_e state_q, state_d;

    logic                 ccw_q, ccw_d;         // direction of the running command
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic                 rot_a_q, rot_a_d;
    logic                 rot_b_q, rot_b_d;
    logic                 rot_c_q, rot_c_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 tmr_load;
    logic [ROT_TMR_W-1:0] tmr_val;
    logic                 tmr_tc;
    logic [1:0]           lv;                   // {leading, trailing}

    assign accept = cmd_valid && (state_q == ST_IDLE);

    rotary_phase_timer u_timer (
        .Fg_clk     (Fg_clk),
        .Resetn     (Resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    // State register
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, detent counter and timer reloads
    always_comb begin
        state_d     = state_q;
        ccw_d       = ccw_q;
        remaining_d = remaining_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ccw_d    = (cmd_op == ROT_OP_CCW);
                    tmr_load = 1'b1;
                    case (cmd_op)
                        ROT_OP_CW, ROT_OP_CCW: begin
                            if (cmd_count != '0) begin
                                state_d     = ST_PH1;
                                remaining_d = cmd_count;
                                tmr_val     = PH_LOAD;
                            end else begin
                                // A one-cycle GAP with nothing left retires
                                // the command without touching the lines.
                                state_d = ST_GAP;
                            end
                        end
                        ROT_OP_BTN: state_d = ST_BTN;
                        ROT_OP_RSVD: state_d = ST_GAP;
                        default: state_d = ST_GAP;
                    endcase
                end
            end
            ST_PH1: begin
                if (tmr_tc) begin
                    state_d  = ST_PH2;
                    tmr_load = 1'b1;
                    tmr_val  = PH_LOAD;
                end
            end
            ST_PH2: begin
                if (tmr_tc) begin
                    state_d  = ST_PH3;
                    tmr_load = 1'b1;
                    tmr_val  = PH_LOAD;
                end
            end
            ST_PH3, ST_BTN: begin
                if (tmr_tc) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                // Abort is looked at only here, so a detent is never cut short.
                if (tmr_tc) begin
                    if (remaining_q > REM_ONE && !cmd_abort) begin
                        state_d     = ST_PH1;
                        remaining_d = remaining_q - REM_ONE;
                        tmr_load    = 1'b1;
                        tmr_val     = PH_LOAD;
                    end else begin
                        state_d     = ST_IDLE;
                        remaining_d = '0;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = '0;
            end
        endcase
    end

    // Output logic: line levels follow the state being entered, so the
    // registered lines change on the same edge as the state.
    always_comb begin
        lv      = phase_levels(state_d);
        rot_a_d = ccw_d ? lv[1] : lv[0];
        rot_b_d = ccw_d ? lv[0] : lv[1];
        rot_c_d = (state_d == ST_BTN);
        done_d  = (state_q == ST_GAP) && (state_d == ST_IDLE);
    end

    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            remaining_q <= '0;
            rot_a_q     <= ROT_AB_IDLE;
            rot_b_q     <= ROT_AB_IDLE;
            rot_c_q     <= ROT_C_IDLE;
            done_q      <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            rot_a_q     <= rot_a_d;
            rot_b_q     <= rot_b_d;
            rot_c_q     <= rot_c_d;
            done_q      <= done_d;
        end
    end

    // Direction only matters while a command runs; it is reloaded on accept.
    always_ff @(posedge Fg_clk) begin
        ccw_q <= ccw_d;
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign Rot_A     = rot_a_q;
    assign Rot_B     = rot_b_q;
    assign Rot_C     = rot_c_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule
